// File: rtl/line_drive_controller.sv
// Line-following drive controller: owns the shared PWM period counter, filters the
// three line sensors once per period and steers both wheels at period boundaries.
module line_drive_controller #(
  parameter int PERIOD       = 122880,
  parameter int CW           = 17,
  parameter int LOST_PERIODS = 50
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    sensor,
  output logic [CW-1:0] count_out,
  output logic          period_start,
  output logic          dir_left,
  output logic          dir_right,
  output logic          en_left,
  output logic          en_right,
  output logic [2:0]    state_dbg
);

  localparam int LW = (LOST_PERIODS > 1) ? $clog2(LOST_PERIODS) : 1;
  localparam logic [LW-1:0] LOST_LAST = LW'(LOST_PERIODS - 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(PERIOD - 1);

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_FORWARD = 3'd1,
    ST_GLEFT   = 3'd2,
    ST_SLEFT   = 3'd3,
    ST_GRIGHT  = 3'd4,
    ST_SRIGHT  = 3'd5,
    ST_LOST    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    TURN_NONE  = 2'd0,
    TURN_LEFT  = 2'd1,
    TURN_RIGHT = 2'd2
  } turn_t;

  typedef struct packed {
    logic en_l;
    logic en_r;
    logic dir_l;
    logic dir_r;
  } drive_t;

  localparam drive_t DRIVE_STOP    = '{en_l: 1'b0, en_r: 1'b0, dir_l: 1'b1, dir_r: 1'b1};
  localparam drive_t DRIVE_FORWARD = '{en_l: 1'b1, en_r: 1'b1, dir_l: 1'b1, dir_r: 1'b1};
  localparam drive_t DRIVE_GLEFT   = '{en_l: 1'b0, en_r: 1'b1, dir_l: 1'b1, dir_r: 1'b1};
  localparam drive_t DRIVE_SLEFT   = '{en_l: 1'b1, en_r: 1'b1, dir_l: 1'b0, dir_r: 1'b1};
  localparam drive_t DRIVE_GRIGHT  = '{en_l: 1'b1, en_r: 1'b0, dir_l: 1'b1, dir_r: 1'b1};
  localparam drive_t DRIVE_SRIGHT  = '{en_l: 1'b1, en_r: 1'b1, dir_l: 1'b1, dir_r: 1'b0};

  function automatic drive_t drive_for(input state_t st, input turn_t turn);
    drive_t d;
    case (st)
      ST_FORWARD: d = DRIVE_FORWARD;
      ST_GLEFT:   d = DRIVE_GLEFT;
      ST_SLEFT:   d = DRIVE_SLEFT;
      ST_GRIGHT:  d = DRIVE_GRIGHT;
      ST_SRIGHT:  d = DRIVE_SRIGHT;
      // LOST keeps spinning toward the side the line was last seen on.
      ST_LOST: begin
        case (turn)
          TURN_LEFT:  d = DRIVE_SLEFT;
          TURN_RIGHT: d = DRIVE_SRIGHT;
          default:    d = DRIVE_FORWARD;
        endcase
      end
      default:    d = DRIVE_STOP;
    endcase
    return d;
  endfunction

  logic          wrap;
  logic [2:0]    sync_meta, sync_q, sample_q, accepted_q;
  state_t        state, next_state;
  turn_t         last_turn, next_turn;
  logic [LW-1:0] lost_cnt, next_lost;
  drive_t        drive_q, next_drive;

  assign wrap = (count_out == COUNT_LAST);

  // NOTE: every register here, including the sensor filter, gets a reset value so the
  // robot always comes out of reset stopped; sequential state uses non-blocking only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_out    <= '0;
      period_start <= 1'b0;
    end else begin
      count_out    <= wrap ? '0 : count_out + CW'(1);
      period_start <= wrap;
    end
  end

  // Accepted only changes when two consecutive wrap-edge samples agree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta  <= '0;
      sync_q     <= '0;
      sample_q   <= '0;
      accepted_q <= '0;
    end else begin
      sync_meta <= sensor;
      sync_q    <= sync_meta;
      if (wrap) begin
        sample_q <= sync_q;
        if (sync_q == sample_q) accepted_q <= sync_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_STOP;
      last_turn <= TURN_NONE;
      lost_cnt  <= '0;
    end else if (wrap) begin
      state     <= next_state;
      last_turn <= next_turn;
      lost_cnt  <= next_lost;
    end
  end

  // NOTE: all comb outputs get a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    next_turn  = last_turn;
    next_lost  = '0;
    case (accepted_q)
      3'b010, 3'b111, 3'b101: next_state = ST_FORWARD;
      3'b110:                 next_state = ST_GLEFT;
      3'b100:                 next_state = ST_SLEFT;
      3'b011:                 next_state = ST_GRIGHT;
      3'b001:                 next_state = ST_SRIGHT;
      default: begin
        if (state == ST_STOP)
          next_state = ST_STOP;
        else if (state == ST_LOST && lost_cnt == LOST_LAST)
          next_state = ST_STOP;
        else
          next_state = ST_LOST;
      end
    endcase
    if (next_state == ST_GLEFT || next_state == ST_SLEFT)
      next_turn = TURN_LEFT;
    else if (next_state == ST_GRIGHT || next_state == ST_SRIGHT)
      next_turn = TURN_RIGHT;
    if (next_state == ST_LOST && state == ST_LOST)
      next_lost = lost_cnt + LW'(1);
  end

  always_comb begin
    next_drive = drive_for(next_state, next_turn);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    drive_q <= DRIVE_STOP;
    else if (wrap) drive_q <= next_drive;
  end

  assign en_left   = drive_q.en_l;
  assign en_right  = drive_q.en_r;
  assign dir_left  = drive_q.dir_l;
  assign dir_right = drive_q.dir_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_line_drive_controller.sv
// Directed bench for line_drive_controller with a short period and short LOST timeout.
module tb_line_drive_controller;

  localparam int PERIOD = 8;
  localparam int CW     = 17;
  localparam int LOSTP  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    sensor = 3'b010;
  logic [CW-1:0] count_out;
  logic          period_start, dir_left, dir_right, en_left, en_right;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  line_drive_controller #(.PERIOD(PERIOD), .CW(CW), .LOST_PERIODS(LOSTP)) dut (
    .clk(clk), .reset(reset), .sensor(sensor), .count_out(count_out),
    .period_start(period_start), .dir_left(dir_left), .dir_right(dir_right),
    .en_left(en_left), .en_right(en_right), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sensor;
    int         wraps;
    logic [2:0] state;
    logic [3:0] drive;  // {en_l, en_r, dir_l, dir_r}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns at the negedge just after the next wrap edge (period_start high).
  task automatic wait_wrap();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 5 * PERIOD);
    if (!period_start) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout: got no period_start expected one within %0d cycles", 5 * PERIOD);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] st, input logic [3:0] drv);
    check({tag, "_state"}, 32'(state_dbg), 32'(st));
    check({tag, "_drive"}, 32'({en_left, en_right, dir_left, dir_right}), 32'(drv));
  endtask

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{3'b110, 1, 3'd0 + 3'd1, 4'b1111};  // single-period glitch ignored
    vecs[1]  = '{3'b010, 3, 3'd1, 4'b1111};
    vecs[2]  = '{3'b110, 2, 3'd1, 4'b1111};         // accepted but not yet acted on
    vecs[3]  = '{3'b110, 1, 3'd2, 4'b0111};         // GLEFT on third wrap
    vecs[4]  = '{3'b111, 3, 3'd1, 4'b1111};
    vecs[5]  = '{3'b100, 3, 3'd3, 4'b1101};
    vecs[6]  = '{3'b101, 3, 3'd1, 4'b1111};
    vecs[7]  = '{3'b011, 3, 3'd4, 4'b1011};
    vecs[8]  = '{3'b001, 3, 3'd5, 4'b1110};
    vecs[9]  = '{3'b000, 3, 3'd6, 4'b1110};         // LOST, last turn right
    vecs[10] = '{3'b000, 2, 3'd6, 4'b1110};
    vecs[11] = '{3'b000, 1, 3'd0, 4'b0011};         // third wrap in LOST -> STOP
    vecs[12] = '{3'b000, 3, 3'd0, 4'b0011};
    vecs[13] = '{3'b010, 2, 3'd0, 4'b0011};
    vecs[14] = '{3'b010, 1, 3'd1, 4'b1111};
    vecs[15] = '{3'b100, 3, 3'd3, 4'b1101};
    vecs[16] = '{3'b000, 3, 3'd6, 4'b1101};         // LOST, last turn left
    vecs[17] = '{3'b010, 3, 3'd1, 4'b1111};         // recovers one wrap before timeout
    vecs[18] = '{3'b100, 3, 3'd3, 4'b1101};

    // Reset hold with the line centred.
    sensor = 3'b010;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_pstart", 32'(period_start), 32'd0);
    check_outputs("rst", 3'd0, 4'b0011);
    reset = 1'b1;

    // Counter and period_start cadence over the first three periods.
    for (int c = 1; c <= 3 * PERIOD; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("cyc%0d_count", c), 32'(count_out), 32'(c % PERIOD));
      check($sformatf("cyc%0d_pstart", c), 32'(period_start), 32'((c % PERIOD) == 0));
      if (c == PERIOD) check_outputs("wrap1", 3'd0, 4'b0011);
    end
    check_outputs("wrap3", 3'd1, 4'b1111);
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      sensor = vecs[i].sensor;
      repeat (vecs[i].wraps) wait_wrap();
      check_outputs($sformatf("vec%0d", i), vecs[i].state, vecs[i].drive);
      check($sformatf("vec%0d_count", i), 32'(count_out), 32'd0);
    end

    // Asynchronous reset mid-period while in SLEFT.
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_count", 32'(count_out), 32'd0);
    check("async_pstart", 32'(period_start), 32'd0);
    check_outputs("async", 3'd0, 4'b0011);

    // No line ever seen from reset: stays stopped.
    sensor = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int w = 0; w < 6; w++) begin
      wait_wrap();
      check_outputs($sformatf("idle%0d", w), 3'd0, 4'b0011);
    end

    // LOST with no previous turn drives straight ahead.
    sensor = 3'b010;
    repeat (3) wait_wrap();
    check_outputs("fwd_again", 3'd1, 4'b1111);
    sensor = 3'b000;
    repeat (3) wait_wrap();
    check_outputs("lost_none", 3'd6, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
